npusch_bit_scrambler: RTL
=========================

# npusch_bit_scrambler

Gold-sequence bit scrambler for the NB-IoT uplink chain, directly downstream of the channel interleaver. Consumes the interleaver's serial column-read bit stream (one bit per clock when valid), XORs each bit with the 3GPP TS 36.211 length-31 Gold sequence c(n), and presents the scrambled serial stream to the modulation mapper. Supports one codeword per `start`, with a per-codeword `c_init` seed.

## Interface
- `N_BITS`, default 24: bits per codeword; equals interleaver rows × columns (2 × 12).
- `NC`, default 1600: Gold-sequence offset Nc (warm-up shifts).
- `clk`  in  1: clock, all logic on rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle pulse; latch `c_init` and begin warm-up. Honoured only in IDLE.
- `c_init`  in  31: x2 LFSR seed (n_RNTI·2^14 + (nf mod 2)·2^13 + ⌊ns/2⌋·2^9 + N_cell_ID, computed upstream).
- `in_valid`  in  1: `in_bit` valid this cycle.
- `in_bit`  in  1: interleaver output bit.
- `ready`  out  1: high in RUN; upstream may assert `in_valid` only while high.
- `busy`  out  1: high in WARMUP and RUN.
- `out_valid`  out  1: registered; `out_bit` valid.
- `out_bit`  out  1: registered scrambled bit.
- `out_done`  out  1: one-cycle pulse, coincident with the last `out_valid`.

## Operation
- LFSRs: x1[30:0], x2[30:0]. Per shift: x1_new = x1[3] ^ x1[0]; x2_new = x2[3] ^ x2[2] ^ x2[1] ^ x2[0]; both shift right, new bit into [30]. c = x1[0] ^ x2[0] (sampled before the shift).
- On `start` in IDLE: x1 ← 31'h1 (x1(0)=1, rest 0), x2 ← `c_init`, warm-up counter ← 0, bit counter ← 0.
- States:
  - IDLE: `ready`=0, `busy`=0. `start` → WARMUP.
  - WARMUP: shift both LFSRs once per clock, no output. After NC shifts → RUN.
  - RUN: `ready`=1. On `in_valid`: `out_bit` ← `in_bit` ^ c, `out_valid` ← 1, shift LFSRs once, bit counter +1. No `in_valid` → LFSRs hold, `out_valid` ← 0. On the N_BITS-th accepted bit: `out_done` ← 1 with that output, state → IDLE.
- `in_valid` outside RUN: ignored, no output, LFSRs unaffected.
- `start` outside IDLE: ignored (no restart, no `c_init` reload).
- `start` on the cycle RUN→IDLE completes: ignored; a new `start` is needed from IDLE the following cycle.
- Counters: warm-up 11 bits (saturates at NC), bit counter ⌈log2(N_BITS+1)⌉ bits; no wrap within a codeword.

## Timing
- Reset values: `ready`=0, `busy`=0, `out_valid`=0, `out_bit`=0, `out_done`=0, state IDLE, x1=0, x2=0, counters 0.
- `start` at edge T → `busy` high from T+1; `ready` high from T+1+NC (1601 cycles after the `start` edge at default).
- Latency: `in_valid` sampled at edge T → `out_valid`/`out_bit` at T+1. Throughput 1 bit/clock, gaps in `in_valid` preserved 1:1 at the output.
- Last bit accepted at edge T: `ready`/`busy` low from T+1; `out_valid` and `out_done` high in cycle T+1 only.
- `reset` mid-WARMUP or mid-RUN: next cycle all outputs at reset values, state IDLE, partial codeword discarded. No `out_done`.

## Test plan
- Zero-seed check: `c_init`=0, `start`, then 24 consecutive `in_bit`=0 → `out_bit` sequence equals c(0..23) from the bit-exact Python Gold model with Nc=1600; `out_done` on the 24th output; `ready` rises exactly 1601 cycles after `start`.
- Data transparency: `c_init`=31'h12345, two codewords, one all-ones and one all-zeros input → outputs are bitwise complements; each equals the model c(0..23) (or its inverse).
- Gapped input: `c_init`=31'h0ABCDE, `in_valid` asserted every other cycle → 24 outputs identical to the back-to-back run with the same seed; LFSR holds through gaps.
- Protocol guards: `in_valid` pulses during WARMUP and a second `start` with a different `c_init` during RUN → no extra outputs; output stream matches the first seed only.
- Reset mid-operation: `reset` at warm-up cycle 800, and separately after 10 RUN bits → all outputs zero next cycle, no `out_done`; a fresh `start` yields the full correct 24-bit sequence.
- Back-to-back codewords: `start` on the cycle after `out_done` with a new seed → second codeword correct; `start` on the `out_done` cycle itself is ignored.

Source files
------------

// File: rtl/npusch_bit_scrambler.sv
// npusch_bit_scrambler
//   Gold-sequence (length-31) bit scrambler for the NB-IoT uplink chain.
//   Each codeword is seeded via start/c_init. After NC warm-up shifts, each
//   accepted input bit is XORed with c(n) and presented one clock later.
//
// Parameters
//   N_BITS : bits per codeword (interleaver rows x columns)
//   NC     : Gold-sequence offset (warm-up shifts), at most 2047
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   start     : one-cycle pulse; latches c_init and begins warm-up (IDLE only)
//   c_init    : 31-bit x2 seed
//   in_valid  : in_bit valid this cycle (honoured only while ready)
//   in_bit    : interleaver output bit
//   ready     : high in RUN
//   busy      : high in WARMUP and RUN
//   out_valid : registered, out_bit valid
//   out_bit   : registered scrambled bit
//   out_done  : one-cycle pulse with the last out_valid of a codeword
module npusch_bit_scrambler #(
  parameter int N_BITS = 24,
  parameter int NC     = 1600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [30:0] c_init,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        ready,
  output logic        busy,
  output logic        out_valid,
  output logic        out_bit,
  output logic        out_done
);

  localparam int BW = $clog2(N_BITS + 1);
  localparam logic [10:0]   WARM_LAST = 11'(NC - 1);
  localparam logic [10:0]   WARM_SAT  = 11'(NC);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t        state;
  logic [30:0]   x1;
  logic [30:0]   x2;
  logic [10:0]   warm_cnt;
  logic [BW-1:0] bit_cnt;
  logic          c;

  // Gold sequence output is taken from the current LFSR state, before the shift.
  assign c = x1[0] ^ x2[0];

  function automatic logic [30:0] x1_step(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x1        <= '0;
      x2        <= '0;
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_done  <= 1'b0;
      case (state)
        IDLE: begin
          // out_done high means the previous codeword finished on the last
          // edge; a start seen in that cycle is dropped so a new codeword
          // always needs a start from a settled IDLE.
          if (start && !out_done) begin
            x1       <= 31'h1;
            x2       <= c_init;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            if (NC == 0) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= WARMUP;
            end
          end
        end

        WARMUP: begin
          x1 <= x1_step(x1);
          x2 <= x2_step(x2);
          if (warm_cnt != WARM_SAT) begin
            warm_cnt <= warm_cnt + 11'd1;
          end
          if (warm_cnt == WARM_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end

        RUN: begin
          if (in_valid) begin
            out_bit   <= in_bit ^ c;
            out_valid <= 1'b1;
            x1        <= x1_step(x1);
            x2        <= x2_step(x2);
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              out_done <= 1'b1;
              state    <= IDLE;
              ready    <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
